tl_corrupt_beat_queue: RTL
==========================

// Module: tl_corrupt_beat_queue
// PURPOSE
//  Ready/valid FIFO controller for TileLink data beats with per-beat corrupt flag.
//  Sits directly upstream of the 1-bit corrupt-flag RAM and its companion data RAM.
//  Drives their write port on enqueue and their read port on dequeue.
//  Owns pointers, occupancy, backpressure and a sticky corrupt-seen indicator.
// PARAMETERS
//  DATA_W  64  beat data width in bits
//  DEPTH   8   entries; power of two, >= 2; ADDR_W = $clog2(DEPTH) (3 at default)
// PORTS
//  clock         in   1         single clock; all state on posedge
//  reset_n       in   1         asynchronous assert, active-low reset
//  enq_valid     in   1         upstream beat valid
//  enq_ready     out  1         queue can accept a beat
//  enq_data      in   DATA_W    beat payload
//  enq_corrupt   in   1         beat corrupt flag
//  deq_valid     out  1         head beat available
//  deq_ready     in   1         downstream accepts head beat
//  deq_data      out  DATA_W    head beat payload
//  deq_corrupt   out  1         head beat corrupt flag
//  flush         in   1         synchronous empty; wins over enq/deq that cycle
//  count         out  ADDR_W+1  current occupancy, 0..DEPTH
//  corrupt_seen  out  1         sticky: a corrupt beat was enqueued since reset/flush
// BEHAVIOUR
//  Reset (reset_n low, async): enq_ptr=0, deq_ptr=0, maybe_full=0, corrupt_seen=0.
//   Resulting outputs: count=0, deq_valid=0, enq_ready=1. RAM contents not reset.
//  State: enq_ptr, deq_ptr (ADDR_W, wrap DEPTH-1 -> 0 naturally), maybe_full.
//   empty = (enq_ptr==deq_ptr) & !maybe_full; full = (enq_ptr==deq_ptr) & maybe_full.
//  enq_ready = !full; deq_valid = !empty. Both combinational from registers only.
//   No combinational path from enq_valid/deq_ready to either ready/valid.
//  do_enq = enq_valid & enq_ready & !flush; do_deq = deq_valid & deq_ready & !flush.
//  do_enq: RAM[enq_ptr] <= {enq_data, enq_corrupt} at posedge; enq_ptr++.
//  do_deq: deq_ptr++. deq_data/deq_corrupt = RAM[deq_ptr] combinationally.
//   Read enable = deq_valid; outputs are don't-care (X allowed) when !deq_valid.
//  maybe_full <= do_enq when do_enq != do_deq; unchanged when both or neither.
//  No flow-through: enq on empty shows deq_valid=1 the NEXT cycle (latency 1).
//  No pipe mode: when full, enq_ready=0 even if deq fires that cycle.
//  Simultaneous enq+deq (not empty, not full): count unchanged, both ptrs advance.
//  count = maybe_full&&ptr_eq ? DEPTH : (enq_ptr - deq_ptr) mod DEPTH.
//  flush: enq_ptr=deq_ptr=0, maybe_full=0, corrupt_seen=0 next cycle;
//   a beat presented with flush is dropped (not written, not counted).
//  corrupt_seen <= corrupt_seen | (do_enq & enq_corrupt); flush/reset clear it.
//  Reset mid-operation: all state cleared immediately; in-flight beats lost;
//   upstream must re-send. deq_valid drops to 0 asynchronously with reset_n.
//  Assertions: no do_enq when full; no do_deq when empty; count <= DEPTH.
// STRUCTURE
//  Shared package tl_queue_pkg: DEPTH default, ADDR_W function, beat_t struct
//   {logic [DATA_W-1:0] data; logic corrupt;} used by this block and the RAMs.
//  One sub-module: queue_ram_2p (WIDTH, DEPTH): one write port (en, addr, data,
//   posedge write) and one combinational read port (en, addr); instantiated
//   once for data and once (WIDTH=1) for the corrupt flag.
//  Controller (pointers, flags, count, sticky) lives in this module, no FSM beyond
//   the empty/partial/full encoding implied by ptrs + maybe_full.
// TESTING
//  Reset -> count=0, deq_valid=0, enq_ready=1, corrupt_seen=0.
//  Enq 8 beats data=0x10..0x17, corrupt only on 0x13 -> count=8, enq_ready=0,
//   corrupt_seen=1; deq all -> data 0x10..0x17 in order, deq_corrupt=1 only for 0x13.
//  Fill to 8, assert enq_valid+deq_ready same cycle -> only deq fires, count=7.
//  Hold 4 entries, continuous enq+deq for 20 cycles -> count stays 4, ptrs wrap,
//   FIFO order preserved across wrap.
//  Count=5 with corrupt_seen=1, flush with enq_valid=1 -> next cycle count=0,
//   deq_valid=0, corrupt_seen=0, flushed-cycle beat never appears at deq.
//  Deassert reset_n asynchronously mid-burst at count=3 -> deq_valid=0 and
//   count=0 before next clock edge; queue accepts new beats after release.

Source files
------------

// File: rtl/tl_queue_pkg.sv
// tl_queue_pkg: shared defaults, beat record and address-width helper for the beat queue and its RAMs
package tl_queue_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF = 8;
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic corrupt;
  } beat_t;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/queue_ram_2p.sv
// queue_ram_2p: storage array with one posedge write port and one combinational read port
module queue_ram_2p
  import tl_queue_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  // write port; contents are deliberately not reset
  always_ff @(posedge clk_i)
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  assign rd_data_o = rd_en_i ? mem_q[rd_addr_i] : '0;
endmodule

// File: rtl/tl_corrupt_beat_queue.sv
// tl_corrupt_beat_queue: ready/valid FIFO controller for TileLink beats with per-beat corrupt flag
module tl_corrupt_beat_queue
  import tl_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              enq_valid_i,
  output logic              enq_ready_o,
  input  logic [DATA_W-1:0] enq_data_i,
  input  logic              enq_corrupt_i,
  output logic              deq_valid_o,
  input  logic              deq_ready_i,
  output logic [DATA_W-1:0] deq_data_o,
  output logic              deq_corrupt_o,
  input  logic              flush_i,
  output logic [ADDR_W:0]   count_o,
  output logic              corrupt_seen_o
);
  logic [ADDR_W-1:0] enq_ptr_q, enq_ptr_d, deq_ptr_q, deq_ptr_d;
  logic maybe_full_q, maybe_full_d, corrupt_seen_q, corrupt_seen_d;
  logic ptr_eq, empty, full, do_enq, do_deq;
  // occupancy flags come from registers only, so ready/valid never depend on the partner handshake
  assign ptr_eq = enq_ptr_q == deq_ptr_q;
  assign empty = ptr_eq & ~maybe_full_q;
  assign full = ptr_eq & maybe_full_q;
  assign enq_ready_o = ~full;
  assign deq_valid_o = ~empty;
  assign do_enq = enq_valid_i & enq_ready_o & ~flush_i;
  assign do_deq = deq_valid_o & deq_ready_i & ~flush_i;
  assign count_o = full ? (ADDR_W+1)'(DEPTH) : {1'b0, enq_ptr_q - deq_ptr_q};
  assign corrupt_seen_o = corrupt_seen_q;
  // next state: flush clears everything, otherwise pointers step and maybe_full follows the odd handshake
  always_comb begin
    enq_ptr_d = do_enq ? enq_ptr_q + 1'b1 : enq_ptr_q;
    deq_ptr_d = do_deq ? deq_ptr_q + 1'b1 : deq_ptr_q;
    maybe_full_d = (do_enq != do_deq) ? do_enq : maybe_full_q;
    corrupt_seen_d = corrupt_seen_q | (do_enq & enq_corrupt_i);
    if (flush_i) begin
      enq_ptr_d = '0;
      deq_ptr_d = '0;
      maybe_full_d = 1'b0;
      corrupt_seen_d = 1'b0;
    end
  end
  // controller state register with asynchronous clear
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      maybe_full_q <= 1'b0;
      corrupt_seen_q <= 1'b0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
      corrupt_seen_q <= corrupt_seen_d;
    end
  queue_ram_2p #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_data_ram (
    .clk_i(clock_i), .wr_en_i(do_enq), .wr_addr_i(enq_ptr_q), .wr_data_i(enq_data_i),
    .rd_en_i(deq_valid_o), .rd_addr_i(deq_ptr_q), .rd_data_o(deq_data_o)
  );
  queue_ram_2p #(.WIDTH(1), .DEPTH(DEPTH)) u_flag_ram (
    .clk_i(clock_i), .wr_en_i(do_enq), .wr_addr_i(enq_ptr_q), .wr_data_i(enq_corrupt_i),
    .rd_en_i(deq_valid_o), .rd_addr_i(deq_ptr_q), .rd_data_o(deq_corrupt_o)
  );
  // handshake sanity: never write into a full queue, never read an empty one
  always_ff @(posedge clock_i)
    if (reset_n_i) begin
      assert (!(do_enq && full));
      assert (!(do_deq && empty));
      assert (count_o <= (ADDR_W+1)'(DEPTH));
    end
endmodule
